// File: rtl/reaction_referee.sv
// Reaction-game referee: arms a random-free fixed delay, lights the go lamp,
// judges the first lockout press (or its absence) and keeps score to WIN_SCORE.
module reaction_referee #(
    parameter int unsigned WAIT_CYCLES   = 8,
    parameter int unsigned WINDOW_CYCLES = 16,
    parameter int unsigned WIN_SCORE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       push,
    input  logic       tie,
    input  logic       right,
    output logic       clear,
    output logic       lamp,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       point_l,
    output logic       point_r,
    output logic       false_start,
    output logic       tie_flag,
    output logic       no_press,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_GO, S_RESULT, S_DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST   = 16'(WAIT_CYCLES - 1);
    localparam logic [15:0] WINDOW_LAST = 16'(WINDOW_CYCLES - 1);
    localparam logic [3:0]  WIN_S       = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
    logic        clear_q, clear_d, lamp_q, lamp_d;
    logic        point_l_q, point_l_d, point_r_q, point_r_d;
    logic        false_start_q, false_start_d, tie_flag_q, tie_flag_d;
    logic        no_press_q, no_press_d, game_over_q, game_over_d, busy_q, busy_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_S) ? WIN_S : s + 4'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        point_l_d     = 1'b0;
        point_r_d     = 1'b0;
        false_start_d = 1'b0;
        tie_flag_d    = 1'b0;
        no_press_d    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_ARM;
                cnt_d   = '0;
            end
            S_ARM: begin
                // A press always beats the terminal count in the same cycle.
                if (push) begin
                    state_d       = S_RESULT;
                    false_start_d = 1'b1;
                    if (tie)        tie_flag_d = 1'b1;
                    else if (right) point_l_d  = 1'b1;
                    else            point_r_d  = 1'b1;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_GO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GO: begin
                if (push) begin
                    state_d = S_RESULT;
                    if (tie)        tie_flag_d = 1'b1;
                    else if (right) point_r_d  = 1'b1;
                    else            point_l_d  = 1'b1;
                end else if (cnt_q == WINDOW_LAST) begin
                    state_d    = S_RESULT;
                    no_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESULT: begin
                state_d = (score_l_q == WIN_S || score_r_q == WIN_S) ? S_DONE : S_IDLE;
                cnt_d   = '0;
            end
            S_DONE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Scores land on the edge that enters RESULT so they are visible there.
        if (point_l_d) score_l_d = sat_inc(score_l_q);
        if (point_r_d) score_r_d = sat_inc(score_r_q);
        clear_d     = (state_d == S_CLEAR);
        lamp_d      = (state_d == S_GO);
        game_over_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            clear_q       <= 1'b0;
            lamp_q        <= 1'b0;
            point_l_q     <= 1'b0;
            point_r_q     <= 1'b0;
            false_start_q <= 1'b0;
            tie_flag_q    <= 1'b0;
            no_press_q    <= 1'b0;
            game_over_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            clear_q       <= clear_d;
            lamp_q        <= lamp_d;
            point_l_q     <= point_l_d;
            point_r_q     <= point_r_d;
            false_start_q <= false_start_d;
            tie_flag_q    <= tie_flag_d;
            no_press_q    <= no_press_d;
            game_over_q   <= game_over_d;
            busy_q        <= busy_d;
        end
    end

    assign clear       = clear_q;
    assign lamp        = lamp_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign point_l     = point_l_q;
    assign point_r     = point_r_q;
    assign false_start = false_start_q;
    assign tie_flag    = tie_flag_q;
    assign no_press    = no_press_q;
    assign game_over   = game_over_q;
    assign busy        = busy_q;

endmodule
